// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq
//  master (producer/consumer side): drives in_valid, a, b, alu_op, out_ready
//  slave  (alu_seq): drives in_ready, out_valid, alu_result, zero, carry, negative, overflow
interface alu_seq_if #(parameter int WIDTH = 8);
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] a, b, alu_result;
   logic [4:0]       alu_op;
   logic             zero, carry, negative, overflow;
   modport master (
      output in_valid, a, b, alu_op, out_ready,
      input  in_ready, out_valid, alu_result, zero, carry, negative, overflow
   );
   modport slave (
      input  in_valid, a, b, alu_op, out_ready,
      output in_ready, out_valid, alu_result, zero, carry, negative, overflow
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, single-cycle base ops plus multi-cycle MUL/SHL/SHR/SRA with registered flags
//  clk, rst_n (async active-low); bus: in_valid/in_ready, a, b, alu_op in; out_valid/out_ready,
//  alu_result, zero, carry, negative, overflow out
module alu_seq #(
   parameter int WIDTH = 8,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] ra, sh, sh_nx, s_res, wr_res;
   logic [2*WIDTH-1:0] p, p_nx;
   logic [WIDTH:0]   add_w, sub_w, mul_sum;
   logic [4:0]       op;
   logic [SHW:0]     cnt;
   logic [SHW-1:0]   amt;
   logic             s_c, s_v, s_multi, sb, wr_en, wr_c, wr_v;
   assign amt = bus.b[SHW-1:0];
   assign bus.in_ready = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   always_comb begin
      add_w = {1'b0, bus.a} + {1'b0, bus.b};
      sub_w = {1'b0, bus.a} - {1'b0, bus.b};
      s_res = '0;
      s_c = 1'b0;
      s_v = 1'b0;
      if (bus.alu_op[4]) begin
         // only reached as a single-cycle op for zero-amount shifts or undefined ext codes
         s_res = (bus.alu_op[3:2] == 2'b00 && bus.alu_op[1:0] != 2'b00) ? bus.a : '0;
      end else begin
         casez (bus.alu_op[3:0])
            4'b001?: s_res = bus.b;
            4'b?100: begin
               s_res = add_w[WIDTH-1:0];
               s_c = add_w[WIDTH];
               s_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b?101: begin
               s_res = sub_w[WIDTH-1:0];
               s_c = sub_w[WIDTH];
               s_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b?111: s_res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
            4'b?110: s_res = bus.a & bus.b;
            4'b100?: s_res = bus.a | bus.b;
            4'b101?: s_res = bus.a ^ bus.b;
            default: s_res = '0;
         endcase
      end
      s_multi = bus.alu_op[4] && (bus.alu_op[3:0] == 4'd0 || (bus.alu_op[3:2] == 2'b00 && amt != '0));
   end
   // one shift-add step: p holds {partial hi, remaining multiplier bits}
   always_comb begin
      mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, ra} : '0);
      p_nx = {mul_sum, p[WIDTH-1:1]};
      sh_nx = op[1:0] == 2'b01 ? {sh[WIDTH-2:0], 1'b0} :
              op[1:0] == 2'b10 ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-1], sh[WIDTH-1:1]};
      sb = op[1:0] == 2'b01 ? sh[WIDTH-1] : sh[0];
   end
   always_comb begin
      state_nx = state;
      wr_en = 1'b0;
      wr_res = s_res;
      wr_c = s_c;
      wr_v = s_v;
      case (state)
         IDLE: if (bus.in_valid) begin
            state_nx = s_multi ? BUSY : DONE;
            wr_en = !s_multi;
         end
         BUSY: if (cnt == (SHW+1)'(1)) begin
            state_nx = DONE;
            wr_en = 1'b1;
            wr_res = op[1:0] == 2'b00 ? p_nx[WIDTH-1:0] : sh_nx;
            wr_c = op[1:0] == 2'b00 ? |p_nx[2*WIDTH-1:WIDTH] : sb;
            wr_v = 1'b0;
         end
         DONE: if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra <= '0;
         sh <= '0;
         p <= '0;
         op <= '0;
         cnt <= '0;
         bus.alu_result <= '0;
         bus.zero <= 1'b0;
         bus.carry <= 1'b0;
         bus.negative <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         if (state == IDLE && bus.in_valid) begin
            ra <= bus.a;
            sh <= bus.a;
            p <= {{WIDTH{1'b0}}, bus.b};
            op <= bus.alu_op;
            cnt <= bus.alu_op[3:0] == 4'd0 ? (SHW+1)'(WIDTH) : {1'b0, amt};
         end else if (state == BUSY) begin
            p <= p_nx;
            sh <= sh_nx;
            cnt <= cnt - 1'b1;
         end
         if (wr_en) begin
            bus.alu_result <= wr_res;
            bus.zero <= (wr_res == '0);
            bus.carry <= wr_c;
            bus.negative <= wr_res[WIDTH-1];
            bus.overflow <= wr_v;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8
module tb_alu_seq;
   typedef struct packed {
      logic [7:0] r;
      logic       z, c, n, v;
   } res_t;
   typedef struct packed {
      res_t       f;
      logic [7:0] lat;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;
   exp_t sb[$];
   alu_seq_if #(.WIDTH(8)) bus ();
   alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [4:0] op);
      exp_t e;
      logic [8:0] t;
      logic [15:0] m;
      int s;
      s = int'(b[2:0]);
      e = '0;
      e.lat = 8'd1;
      if (!op[4]) begin
         case (op[3:0])
            4'd2, 4'd3: e.f.r = b;
            4'd4, 4'd12: begin
               t = a + b;
               e.f.r = t[7:0];
               e.f.c = t[8];
               e.f.v = (a[7] == b[7]) && (e.f.r[7] != a[7]);
            end
            4'd5, 4'd13: begin
               e.f.r = a - b;
               e.f.c = (a < b);
               e.f.v = (a[7] != b[7]) && (e.f.r[7] != a[7]);
            end
            4'd7, 4'd15: e.f.r = (a < b) ? 8'd1 : 8'd0;
            4'd6, 4'd14: e.f.r = a & b;
            4'd8, 4'd9: e.f.r = a | b;
            4'd10, 4'd11: e.f.r = a ^ b;
            default: e.f.r = 8'd0;
         endcase
      end else begin
         case (op[3:0])
            4'd0: begin
               m = a * b;
               e.f.r = m[7:0];
               e.f.c = |m[15:8];
               e.lat = 8'd9;
            end
            4'd1: begin
               e.f.r = a << s;
               e.f.c = (s != 0) ? a[8-s] : 1'b0;
               e.lat = 8'(1 + s);
            end
            4'd2: begin
               e.f.r = a >> s;
               e.f.c = (s != 0) ? a[s-1] : 1'b0;
               e.lat = 8'(1 + s);
            end
            4'd3: begin
               e.f.r = 8'($signed(a) >>> s);
               e.f.c = (s != 0) ? a[s-1] : 1'b0;
               e.lat = 8'(1 + s);
            end
            default: e.f.r = 8'd0;
         endcase
      end
      e.f.z = (e.f.r == 8'd0);
      e.f.n = e.f.r[7];
      return e;
   endfunction
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus.a = a;
      bus.b = b;
      bus.alu_op = op;
      bus.in_valid = 1'b1;
      sb.push_back(model(a, b, op));
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask
   // waits for out_valid (lat=FF on timeout), samples outputs, then completes the handshake
   task automatic collect(output exp_t o);
      o = '0;
      o.lat = 8'hFF;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            o.lat = 8'(i);
            break;
         end
      end
      o.f = {bus.alu_result, bus.zero, bus.carry, bus.negative, bus.overflow};
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
      else passed++;
      total++;
      if ({bus.alu_result, bus.zero, bus.carry, bus.negative, bus.overflow} !== 12'h000)
         $display("FAIL reset_outputs got %h want 000", {bus.alu_result, bus.zero, bus.carry, bus.negative, bus.overflow});
      else passed++;
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      else passed++;
      rst_n = 1'b1;
   endtask
   task automatic run_table(input string name, input logic [20:0] tbl[]);
      exp_t o, e;
      foreach (tbl[i]) begin
         issue(tbl[i][20:13], tbl[i][12:5], tbl[i][4:0]);
         collect(o);
         e = sb.pop_front();
         total++;
         if (o.f !== e.f) $display("FAIL %s[%0d] r/zcnv got %h/%b want %h/%b", name, i, o.f.r, o.f[3:0], e.f.r, e.f[3:0]);
         else passed++;
         total++;
         if (o.lat !== e.lat) $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, o.lat, e.lat);
         else passed++;
      end
   endtask
   task automatic test_add;
      run_table("add", '{{8'hFF, 8'h01, 5'b00100}, {8'h7F, 8'h01, 5'b01100}, {8'h12, 8'h34, 5'b00100}});
   endtask
   task automatic test_sub_cmp;
      run_table("subcmp", '{{8'h80, 8'h01, 5'b00101}, {8'h03, 8'h05, 5'b00111},
                            {8'h05, 8'h03, 5'b01111}, {8'h03, 8'h05, 5'b01101}});
   endtask
   task automatic test_logic;
      run_table("logic", '{{8'hF0, 8'h3C, 5'b00110}, {8'hF0, 8'h0F, 5'b01000},
                           {8'hFF, 8'h0F, 5'b01011}, {8'h55, 8'h9A, 5'b00011}, {8'h55, 8'h9A, 5'b00001}});
   endtask
   task automatic test_mul;
      run_table("mul", '{{8'h10, 8'h11, 5'b10000}, {8'hFF, 8'hFF, 5'b10000},
                         {8'h00, 8'h37, 5'b10000}, {8'h0B, 8'h0D, 5'b10000}});
   endtask
   task automatic test_shift;
      run_table("shift", '{{8'h90, 8'h03, 5'b10011}, {8'h81, 8'h00, 5'b10001}, {8'h81, 8'h01, 5'b10001},
                           {8'h81, 8'h07, 5'b10010}, {8'h80, 8'h07, 5'b10011}, {8'hA5, 8'hF2, 5'b10010},
                           {8'h3C, 8'h05, 5'b10001}, {8'h77, 8'h01, 5'b10100}});
   endtask
   task automatic test_back_to_back;
      logic [20:0] tbl[];
      tbl = new[16];
      foreach (tbl[i]) tbl[i] = {8'($urandom), 8'($urandom), 5'($urandom_range(0, 31))};
      run_table("rand", tbl);
   endtask
   task automatic test_backpressure;
      exp_t e, o;
      res_t held;
      int n;
      issue(8'h12, 8'h34, 5'b00100);
      e = sb.pop_front();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 40);
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid got %b want 1", bus.out_valid);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         held = {bus.alu_result, bus.zero, bus.carry, bus.negative, bus.overflow};
         total++;
         if (held !== e.f || bus.out_valid !== 1'b1) $display("FAIL bp_hold[%0d] got %h/%b want %h/1", i, held, bus.out_valid, e.f);
         else passed++;
         total++;
         if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready);
         else passed++;
         bus.in_valid = 1'b1;
         bus.a = 8'hAA;
         bus.b = 8'h01;
         bus.alu_op = 5'b01010;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL bp_release valid/ready got %b%b want 01", bus.out_valid, bus.in_ready);
      else passed++;
      total++;
      if (bus.alu_result !== e.f.r) $display("FAIL bp_idle_hold got %h want %h", bus.alu_result, e.f.r);
      else passed++;
      issue(8'h20, 8'h02, 5'b00101);
      collect(o);
      e = sb.pop_front();
      total++;
      if (o.f !== e.f || o.lat !== e.lat) $display("FAIL bp_next got %h/%0d want %h/%0d", o.f, o.lat, e.f, e.lat);
      else passed++;
   endtask
   task automatic test_reset_mid;
      int seen;
      issue(8'h10, 8'h11, 5'b10000);
      void'(sb.pop_front());
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.out_valid, bus.alu_result, bus.zero, bus.carry, bus.negative, bus.overflow} !== 13'h0)
         $display("FAIL midrst_outputs got %b/%h want 0/00", bus.out_valid, bus.alu_result);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      total++;
      if (seen !== 0) $display("FAIL midrst_no_output got %0d valid cycles want 0", seen);
      else passed++;
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.alu_op = '0;
      test_reset;
      test_add;
      test_sub_cmp;
      test_logic;
      test_mul;
      test_shift;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
